// File: rtl/fetch_wf_scheduler_pkg.sv
// Shared fetch-stage definitions for the wavefront fetch scheduler.
package fetch_wf_scheduler_pkg;

    localparam int DEF_NUM_WF  = 40;
    localparam int DEF_WF_ID_W = 6;
    localparam int DEF_MAX_OUT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/adder7bit.sv
// 7-bit ripple-carry adder used for pointer arithmetic.
module adder7bit (
    input  logic [6:0] a,
    input  logic [6:0] b,
    input  logic       cin,
    output logic [6:0] sum,
    output logic       cout
);

    logic [7:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 7; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[7];

endmodule

// File: rtl/fetch_rr_pick.sv
// Round-robin picker: first candidate at or after last_ptr+1, wrapping at NUM_WF.
module fetch_rr_pick
    import fetch_wf_scheduler_pkg::*;
#(
    parameter int NUM_WF  = DEF_NUM_WF,
    parameter int WF_ID_W = DEF_WF_ID_W
) (
    input  logic [NUM_WF-1:0]  cand,
    input  logic [WF_ID_W-1:0] last_ptr,
    output logic               pick_valid,
    output logic [WF_ID_W-1:0] pick_id
);

    localparam int         SLOTS = 1 << WF_ID_W;
    localparam logic [6:0] NEG_N = 7'(128 - NUM_WF);

    logic [SLOTS-1:0]   cand_ext;
    logic [NUM_WF-1:0]  rot;
    logic [WF_ID_W-1:0] idx [NUM_WF];

    always_comb begin
        cand_ext             = '0;
        cand_ext[NUM_WF-1:0] = cand;
    end

    // Adding 128-NUM_WF carries out exactly when the raw index is >= NUM_WF.
    for (genvar k = 0; k < NUM_WF; k++) begin : g_slot
        logic [6:0] raw;
        logic [6:0] wrap;
        logic       raw_co;
        logic       ge_n;
        logic       unused_hi;

        adder7bit u_add (
            .a    (7'(last_ptr)),
            .b    (7'(k)),
            .cin  (1'b1),
            .sum  (raw),
            .cout (raw_co)
        );

        adder7bit u_sub (
            .a    (raw),
            .b    (NEG_N),
            .cin  (1'b0),
            .sum  (wrap),
            .cout (ge_n)
        );

        assign idx[k]    = ge_n ? wrap[WF_ID_W-1:0]
                                : raw[WF_ID_W-1:0];
        assign unused_hi = raw_co ^ raw[6] ^ wrap[6];
        assign rot[k]    = cand_ext[idx[k]];
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = NUM_WF - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_valid = 1'b1;
                pick_id    = idx[k];
            end
        end
    end

endmodule

// File: rtl/fetch_wf_scheduler.sv
// Fetch-stage wavefront scheduler: round-robin pick, icache handshake,
// in-flight tracking and outstanding-fetch cap.
module fetch_wf_scheduler
    import fetch_wf_scheduler_pkg::*;
#(
    parameter int NUM_WF  = DEF_NUM_WF,
    parameter int WF_ID_W = DEF_WF_ID_W,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_WF-1:0]  wf_ready,
    output logic               fetch_valid,
    output logic [WF_ID_W-1:0] fetch_wfid,
    input  logic               fetch_ack,
    input  logic               fetch_done,
    input  logic [WF_ID_W-1:0] fetch_done_wfid,
    output logic               fetch_stalled,
    output logic [2:0]         outstanding
);

    localparam logic [2:0] CAP = 3'(MAX_OUT);

    fetch_state_e       state;
    logic [NUM_WF-1:0]  inflight;
    logic [NUM_WF-1:0]  set_mask;
    logic [NUM_WF-1:0]  clr_mask;
    logic [NUM_WF-1:0]  cand;
    logic [WF_ID_W-1:0] last_ptr;
    logic [WF_ID_W-1:0] search_ptr;
    logic               pick_valid;
    logic [WF_ID_W-1:0] pick_id;
    logic               ack_fire;
    logic               done_hit;
    logic [2:0]         cnt_nxt;

    assign ack_fire = (state == ISSUE) && fetch_ack;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            if (ack_fire && fetch_wfid == WF_ID_W'(i))
                set_mask[i] = 1'b1;
            if (fetch_done && fetch_done_wfid == WF_ID_W'(i))
                clr_mask[i] = inflight[i];
        end
    end

    assign done_hit = |clr_mask;
    assign cnt_nxt  = outstanding + 3'(ack_fire) - 3'(done_hit);

    // While a request is pending, the next search starts after it and skips it.
    assign cand       = wf_ready & ~inflight & ~set_mask;
    assign search_ptr = (state == ISSUE) ? fetch_wfid : last_ptr;

    fetch_rr_pick #(
        .NUM_WF  (NUM_WF),
        .WF_ID_W (WF_ID_W)
    ) u_pick (
        .cand       (cand),
        .last_ptr   (search_ptr),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            fetch_valid   <= 1'b0;
            fetch_wfid    <= '0;
            fetch_stalled <= 1'b0;
            outstanding   <= '0;
            inflight      <= '0;
            last_ptr      <= WF_ID_W'(NUM_WF - 1);
        end else begin
            inflight    <= (inflight | set_mask) & ~clr_mask;
            outstanding <= cnt_nxt;
            unique case (state)
                IDLE: begin
                    if (outstanding == CAP) begin
                        state         <= STALL;
                        fetch_stalled <= 1'b1;
                    end else if (pick_valid) begin
                        state       <= ISSUE;
                        fetch_valid <= 1'b1;
                        fetch_wfid  <= pick_id;
                    end
                end
                ISSUE: begin
                    if (fetch_ack) begin
                        last_ptr <= fetch_wfid;
                        if (pick_valid && cnt_nxt < CAP) begin
                            fetch_wfid <= pick_id;
                        end else if (cnt_nxt == CAP) begin
                            state         <= STALL;
                            fetch_valid   <= 1'b0;
                            fetch_stalled <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            fetch_valid <= 1'b0;
                        end
                    end
                end
                STALL: begin
                    if (done_hit) begin
                        state         <= IDLE;
                        fetch_stalled <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    fetch_valid   <= 1'b0;
                    fetch_stalled <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_wf_scheduler.sv
// Scoreboard bench for fetch_wf_scheduler: expected grant order is queued
// with the stimulus and popped on each observed handshake.
module tb_fetch_wf_scheduler;

    localparam int NW  = 40;
    localparam int IDW = 6;
    localparam int MO  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NW-1:0]  wf_ready = '0;
    logic           fetch_valid;
    logic [IDW-1:0] fetch_wfid;
    logic           fetch_ack = 1'b0;
    logic           fetch_done = 1'b0;
    logic [IDW-1:0] fetch_done_wfid = '0;
    logic           fetch_stalled;
    logic [2:0]     outstanding;

    int n_cmp = 0;
    int n_bad = 0;
    int q[$];

    fetch_wf_scheduler #(
        .NUM_WF  (NW),
        .WF_ID_W (IDW),
        .MAX_OUT (MO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wf_ready        (wf_ready),
        .fetch_valid     (fetch_valid),
        .fetch_wfid      (fetch_wfid),
        .fetch_ack       (fetch_ack),
        .fetch_done      (fetch_done),
        .fetch_done_wfid (fetch_done_wfid),
        .fetch_stalled   (fetch_stalled),
        .outstanding     (outstanding)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Handshake completes on the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (rst_n && fetch_valid && fetch_ack) begin
            if (q.size() == 0)
                chk("sb_extra", int'(fetch_wfid), 1000);
            else
                chk("sb_grant", int'(fetch_wfid), q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        wf_ready        = '0;
        fetch_ack       = 1'b0;
        fetch_done      = 1'b0;
        fetch_done_wfid = '0;
        q.delete();
        step();
        step();
        rst_n = 1'b1;
        chk("rst_valid", int'(fetch_valid), 0);
        chk("rst_wfid", int'(fetch_wfid), 0);
        chk("rst_stall", int'(fetch_stalled), 0);
        chk("rst_out", int'(outstanding), 0);
        chk("rst_infl", $countones(dut.inflight), 0);
    endtask

    task automatic pulse_done(input int id);
        fetch_done      = 1'b1;
        fetch_done_wfid = IDW'(id);
        step();
        fetch_done = 1'b0;
    endtask

    task automatic wait_stall(input string tag);
        for (int i = 0; i < 20 && !fetch_stalled; i++) step();
        chk(tag, int'(fetch_stalled), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Sparse ready set, back-to-back grants.
        do_reset();
        wf_ready[0]  = 1'b1;
        wf_ready[5]  = 1'b1;
        wf_ready[39] = 1'b1;
        fetch_ack    = 1'b1;
        q.push_back(0);
        q.push_back(5);
        q.push_back(39);
        repeat (8) step();
        chk("t1_out", int'(outstanding), 3);
        chk("t1_valid", int'(fetch_valid), 0);
        chk("t1_drain", q.size(), 0);

        // Cap reached, then freed slots rotate forward before 2 is revisited.
        do_reset();
        wf_ready  = '1;
        fetch_ack = 1'b1;
        for (int g = 0; g < 4; g++) q.push_back(g);
        wait_stall("t2_stall");
        chk("t2_valid", int'(fetch_valid), 0);
        chk("t2_out", int'(outstanding), 4);
        q.push_back(4);
        pulse_done(2);
        for (int g = 4; g <= 39; g++) begin
            wait_stall("t2_restall");
            q.push_back(g == 39 ? 2 : g + 1);
            pulse_done(g);
        end
        wait_stall("t2_end_stall");
        chk("t2_end_out", int'(outstanding), 4);
        chk("t2_drain", q.size(), 0);

        // Wrap-around past the last slot.
        do_reset();
        fetch_ack    = 1'b1;
        wf_ready[38] = 1'b1;
        q.push_back(38);
        for (int i = 0; i < 10 && outstanding != 3'd1; i++) step();
        chk("t3_first", int'(outstanding), 1);
        wf_ready[1]  = 1'b1;
        wf_ready[39] = 1'b1;
        q.push_back(39);
        q.push_back(1);
        repeat (6) step();
        chk("t3_out", int'(outstanding), 3);
        chk("t3_drain", q.size(), 0);

        // Request held stable while ack is delayed and ready drops.
        do_reset();
        wf_ready[7] = 1'b1;
        for (int i = 0; i < 10 && !fetch_valid; i++) step();
        chk("t4_wfid", int'(fetch_wfid), 7);
        wf_ready = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_v", int'(fetch_valid), 1);
            chk("t4_hold_id", int'(fetch_wfid), 7);
        end
        q.push_back(7);
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        chk("t4_out", int'(outstanding), 1);
        chk("t4_idle", int'(fetch_valid), 0);
        chk("t4_drain", q.size(), 0);

        // Same-edge ack and done, then ignored dones.
        do_reset();
        fetch_ack   = 1'b1;
        wf_ready[3] = 1'b1;
        wf_ready[5] = 1'b1;
        q.push_back(3);
        q.push_back(5);
        for (int i = 0; i < 10 && outstanding != 3'd2; i++) step();
        fetch_ack   = 1'b0;
        chk("t5_pre_out", int'(outstanding), 2);
        wf_ready    = '0;
        wf_ready[9] = 1'b1;
        for (int i = 0; i < 10 && !fetch_valid; i++) step();
        chk("t5_wfid", int'(fetch_wfid), 9);
        q.push_back(9);
        fetch_ack       = 1'b1;
        fetch_done      = 1'b1;
        fetch_done_wfid = IDW'(3);
        step();
        fetch_ack  = 1'b0;
        fetch_done = 1'b0;
        wf_ready   = '0;
        chk("t5_out", int'(outstanding), 2);
        chk("t5_inf9", int'(dut.inflight[9]), 1);
        chk("t5_inf3", int'(dut.inflight[3]), 0);
        pulse_done(12);
        step();
        chk("t5_bogus_out", int'(outstanding), 2);
        chk("t5_bogus_cnt", $countones(dut.inflight), 2);
        chk("t5_bogus_5", int'(dut.inflight[5]), 1);
        pulse_done(45);
        step();
        chk("t5_oor_out", int'(outstanding), 2);
        chk("t5_oor_cnt", $countones(dut.inflight), 2);
        chk("t5_stall", int'(fetch_stalled), 0);
        chk("t5_drain", q.size(), 0);

        // Asynchronous reset while a request is pending.
        do_reset();
        wf_ready[20] = 1'b1;
        wf_ready[30] = 1'b1;
        fetch_ack    = 1'b1;
        q.push_back(20);
        for (int i = 0; i < 10 && outstanding != 3'd1; i++) step();
        fetch_ack = 1'b0;
        chk("t6_pend_v", int'(fetch_valid), 1);
        chk("t6_pend_id", int'(fetch_wfid), 30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_v", int'(fetch_valid), 0);
        chk("t6_async_id", int'(fetch_wfid), 0);
        chk("t6_async_out", int'(outstanding), 0);
        chk("t6_async_inf", $countones(dut.inflight), 0);
        step();
        rst_n     = 1'b1;
        fetch_ack = 1'b1;
        q.push_back(20);
        q.push_back(30);
        repeat (6) step();
        chk("t6_out", int'(outstanding), 2);
        chk("t6_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_wf_scheduler.md
# fetch_wf_scheduler

Round-robin wavefront fetch scheduler for the fetch stage. Each cycle it picks one eligible wavefront slot and presents its ID to the instruction-cache request port with a valid/ack handshake. It tracks which wavefronts have a fetch in flight and caps total outstanding fetches. The rotating search index (pointer + offset, wrapped at NUM_WF) is computed with the existing 7-bit ripple adder.

## Interface

Parameters:
- NUM_WF, 40, number of wavefront slots (≤ 64)
- WF_ID_W, 6, wavefront ID width
- MAX_OUT, 4, maximum outstanding fetches (1..7)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- wf_ready  in  NUM_WF  per-slot eligibility from the wavefront pool
- fetch_valid  out  1  request to the icache
- fetch_wfid  out  WF_ID_W  ID of the requested wavefront
- fetch_ack  in  1  icache accepted the request this cycle
- fetch_done  in  1  a fetch has returned
- fetch_done_wfid  in  WF_ID_W  ID of the returned fetch
- fetch_stalled  out  1  high while the outstanding limit blocks issue
- outstanding  out  3  current in-flight count

## Operation

- Candidate set: wf_ready[i] & ~inflight[i], for i < NUM_WF.
- Pick: the first candidate scanning from last_ptr+1 upward. Each index is (last_ptr+1+k); subtract NUM_WF when the result is ≥ NUM_WF.
- FSM states: IDLE, ISSUE, STALL.
  - IDLE → ISSUE when a candidate exists and outstanding < MAX_OUT. fetch_wfid is registered from the pick.
  - IDLE → STALL when outstanding == MAX_OUT.
  - ISSUE: fetch_valid = 1. fetch_wfid holds stable until fetch_ack. A request is never retracted, even if wf_ready drops.
  - ISSUE, on fetch_ack:
    - set inflight[fetch_wfid];
    - last_ptr ← fetch_wfid;
    - outstanding += 1;
    - next state: ISSUE with a new pick, if a candidate exists excluding the acked ID and the post-ack count < MAX_OUT; otherwise STALL if the count == MAX_OUT; otherwise IDLE.
  - STALL → IDLE on any fetch_done that frees a slot.
- fetch_done with inflight[fetch_done_wfid] = 1: clear the bit and decrement outstanding.
- fetch_done for a wavefront that is not in flight, or with an ID ≥ NUM_WF, is ignored. No state changes.
- Simultaneous ack and valid done on the same edge: outstanding is unchanged. The inflight set and clear both apply. The FSM evaluates the post-update count.
- The done ID cannot equal the acked ID, because the acked slot was not in flight.
- Reset mid-request: fetch_valid drops immediately and asynchronously; the in-flight request is discarded.

## Timing

- Reset values:
  - fetch_valid 0, fetch_wfid 0, fetch_stalled 0, outstanding 0;
  - inflight all 0;
  - last_ptr NUM_WF-1, so the first search starts at slot 0;
  - state IDLE.
- Issue latency: a candidate seen in IDLE in cycle N gives fetch_valid in cycle N+1.
- Throughput: back-to-back grants, one per cycle while ack is held high, until MAX_OUT is reached.
- fetch_done frees the slot for the pick in the next cycle. The freed wavefront is eligible on the following edge.
- fetch_stalled is a registered output and is high exactly in STALL.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Structure

- Shared fetch package holds NUM_WF, WF_ID_W, MAX_OUT defaults and the FSM state encoding (IDLE = 2'd0, ISSUE = 2'd1, STALL = 2'd2).
- Sub-module fetch_rr_pick, combinational:
  - inputs: candidate vector, last_ptr;
  - outputs: pick_valid, pick_id;
  - uses adder7bit instances for the pointer + offset computation and the wrap compare/subtract.
- Top level holds the FSM, inflight register, outstanding counter and last_ptr.

## Test plan

- Reset, then wf_ready = slots {0,5,39}, ack held high → grants 0, 5, 39 on consecutive cycles; outstanding reaches 3.
- MAX_OUT = 4, all slots ready, ack high → 4 grants (0..3); then fetch_stalled = 1 and fetch_valid = 0. fetch_done(2) → next grant is 4; slot 2 is not re-picked before 39 is reached.
- Wrap-around: last grant 38, ready {1,38,39}, slot 38 still in flight → next picks are 39 then 1.
- Hold: fetch_valid with wfid 7; wf_ready[7] drops; ack delayed 3 cycles → wfid stays 7 and valid stays 1 until ack.
- Same-cycle ack(wfid 9) and done(wfid 3), outstanding = 2 → outstanding stays 2, inflight[9] = 1, inflight[3] = 0. A bogus done(wfid 12, not in flight) → no change.
- rst_n asserted while fetch_valid = 1 → all outputs return to reset values asynchronously; the first post-reset grant is the lowest ready slot.
